// File: rtl/audio_pkg.sv
// Constants and types shared by the audio path: silence code, default clock and note frequencies
// used by the per-song beat-to-tone ROMs.
package audio_pkg;

    localparam int unsigned NSIL             = 20000;
    localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;

    localparam int unsigned NOTE_C4 = 261;
    localparam int unsigned NOTE_D4 = 293;
    localparam int unsigned NOTE_E4 = 330;
    localparam int unsigned NOTE_F4 = 349;
    localparam int unsigned NOTE_G4 = 392;
    localparam int unsigned NOTE_A4 = 440;
    localparam int unsigned NOTE_B4 = 494;
    localparam int unsigned NOTE_C5 = 523;
    localparam int unsigned NOTE_C6 = 1046;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StLoad
    } tone_state_e;

endpackage

// File: rtl/seq_divider_32.sv
// Fixed-latency restoring divider: one quotient bit per cycle, 32 cycles after start, MSB first.
module seq_divider_32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [32:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o
);

    logic [32:0] rem_q, rem_d;
    logic [32:0] div_q, div_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [33:0] trial;
    logic [33:0] diff;

    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, div_q};

    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        if (start_i) begin
            rem_d = '0;
            div_d = divisor_i;
            quo_d = dividend_i;
            cnt_d = 6'd32;
        end else if (cnt_q != 6'd0) begin
            if (trial >= {1'b0, div_q}) begin
                rem_d = diff[32:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = trial[32:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    // Flags the final iteration so the sequencer can step to its load state on the same edge
    // that writes the last quotient bit.
    assign done_o     = (cnt_q == 6'd1);
    assign quotient_o = quo_q;

endmodule

// File: rtl/tone_square_gen.sv
// Converts a tone in Hz to a half-period clock count and drives a 50% duty square wave;
// zero or out-of-range tones are silent.
module tone_square_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int unsigned SIL_THRESH = NSIL,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      tone_i,
    input  logic             en_i,
    output logic             audio_out_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] half_period_o
);

    tone_state_e      state_q, state_d;
    logic [31:0]      cur_tone_q, cur_tone_d;
    logic             sil_q, sil_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    logic             silent;
    logic             div_start;
    logic             div_done;
    logic [31:0]      quotient;
    logic [CNT_W-1:0] quo_cnt;

    assign silent  = (tone_i == 32'd0) || (tone_i >= 32'(SIL_THRESH));
    assign quo_cnt = CNT_W'(quotient);

    seq_divider_32 u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .dividend_i (32'(CLK_FREQ)),
        .divisor_i  ({tone_i, 1'b0}),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_comb begin
        state_d    = state_q;
        cur_tone_d = cur_tone_q;
        sil_d      = sil_q;
        hp_d       = hp_q;
        div_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tone_i != cur_tone_q) begin
                    cur_tone_d = tone_i;
                    sil_d      = silent;
                    if (silent) begin
                        state_d = StLoad;
                    end else begin
                        state_d   = StDiv;
                        div_start = 1'b1;
                    end
                end
            end
            StDiv: begin
                if (div_done) state_d = StLoad;
            end
            StLoad: begin
                state_d = StIdle;
                if (sil_q) hp_d = '0;
                else       hp_d = (quo_cnt == '0) ? CNT_W'(1) : quo_cnt;
            end
            default: state_d = StIdle;
        endcase
    end

    // A reload keeps the current level and restarts the half-cycle from zero.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (!en_i || hp_q == '0) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (state_q == StLoad) begin
            cnt_d = '0;
        end else if (cnt_q == hp_q - CNT_W'(1)) begin
            cnt_d = '0;
            out_d = ~out_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cur_tone_q <= 32'(SIL_THRESH);
            sil_q      <= 1'b1;
            hp_q       <= '0;
            cnt_q      <= '0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_tone_q <= cur_tone_d;
            sil_q      <= sil_d;
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
        end
    end

    assign audio_out_o   = out_q;
    assign busy_o        = (state_q != StIdle);
    assign half_period_o = hp_q;

endmodule

// File: doc/tone_square_gen.md
Name: tone_square_gen

Overview:
- Downstream consumer of the per-song beat→tone ROMs; takes the selected 32-bit tone frequency in Hz and drives the Basys3 audio (PMOD buzzer/amp) pin with a 50% duty square wave.
- Converts Hz to a half-period clock count with an iterative sequential divider, then runs a toggle counter.
- Treats the silence code (and any out-of-range frequency) as output held low.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz; the divider dividend.
- SIL_THRESH, 20000: any tone >= this value, or tone == 0, means silence.
- CNT_W, 32: width of the half-period register and toggle counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tone  in  32  requested frequency in Hz, from the music ROM mux.
- en  in  1  audio enable; when 0, output is forced low.
- audio_out  out  1  square-wave audio pin.
- busy  out  1  high while a new tone is being converted.
- half_period  out  CNT_W  active half-period in clk cycles; 0 means silent.

Behaviour:
- Reset (async, rst_n=0):
  - audio_out=0, busy=0, half_period=0.
  - cur_tone=SIL_THRESH, counter=0, FSM=IDLE.
  - Takes effect immediately, including mid-division; the partial result is discarded.
- FSM states are IDLE, DIV and LOAD.
- IDLE:
  - Each cycle, compare tone with cur_tone. If they are equal, stay in IDLE.
  - If they differ: latch cur_tone<=tone.
    - Silent (tone>=SIL_THRESH or tone==0): go to LOAD with result 0.
    - Otherwise: go to DIV with divisor = 2*tone and dividend = CLK_FREQ.
- DIV:
  - Restoring division, one quotient bit per cycle, exactly 32 cycles, MSB first.
  - tone is not sampled during DIV. A tone change while busy is picked up on return to IDLE, via the normal compare.
- LOAD (1 cycle):
  - Non-silent result: half_period <= max(quotient, 1). Quotient truncates toward zero, and 0 is clamped to 1.
  - Silent: half_period <= 0.
  - Counter <= 0. Return to IDLE.
- busy = (state != IDLE).
- Latency: tone changes before edge N (sampled in IDLE at N). DIV occupies edges N+1..N+32, LOAD is at edge N+33, and the new half_period is visible after N+33. The silent path updates after N+1.
- Toggle counter, active when en=1 and half_period != 0:
  - Counter increments every cycle.
  - When counter == half_period-1: counter<=0 and audio_out toggles.
  - Period = 2*half_period cycles; duty is exactly 50%.
- LOAD while sounding:
  - audio_out keeps its current level; no forced edge.
  - The counter restarts from 0 with the new half_period, so the first half-cycle is a full new half_period.
- half_period == 0 or en == 0: audio_out<=0 and counter<=0 on the next edge. The divider and FSM keep running regardless of en.
- Deasserting en and then reasserting it restarts the wave from low with counter=0.
- Widths:
  - The divisor is 2*tone computed in 33 bits; no overflow is possible since tone < SIL_THRESH.
  - The quotient is 32 bits and is truncated to CNT_W.

Decomposition:
- Shared package audio_pkg:
  - NSIL/SIL_THRESH constant.
  - Default CLK_FREQ.
  - Note-frequency constants shared with the music ROMs.
  - FSM state enum {IDLE, DIV, LOAD}.
- One sub-module, seq_divider_32:
  - Interface: start/done handshake, dividend, divisor, quotient.
  - Fixed 32-cycle restoring divider.
  - Instantiated once; the FSM sequences it.

Test Plan:
- Reset release with tone=NSIL (20000), en=1 -> busy stays 0, half_period=0, audio_out=0 forever.
- tone=440, CLK_FREQ=100e6 -> busy high for exactly 33 cycles, half_period=113636, audio_out toggles every 113636 cycles, period 227272.
- tone 440→1046 while sounding -> after 33 cycles half_period=47801, no glitch edge at LOAD, first new half-cycle is 47801 cycles.
- tone changes 261→293 at cycle 10 of DIV -> first conversion completes (half_period=191570), then second runs: half_period=170648 at 34 cycles after returning to IDLE.
- CLK_FREQ=1000 build, tone=600 -> quotient 0 clamped, half_period=1, audio_out toggles every cycle.
- rst_n pulsed low mid-DIV, and en toggled 1→0→1 mid-wave -> all outputs 0 immediately on reset; with en=0, output low next edge; with en=1 again, wave restarts low with counter=0.
